// File: rtl/video_dma_pkg.sv
// Shared definitions for the video DMA swap master: FSM states, DMA control
// register map and status bit positions.
`default_nettype none

package video_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_BACK   = 3'd1,
    S_WR_SWAP   = 3'd2,
    S_WR_EN     = 3'd3,
    S_RD_STATUS = 3'd4,
    S_WAIT_DATA = 3'd5,
    S_CHECK     = 3'd6
  } state_t;

  localparam logic [1:0] REG_BUF     = 2'd0;
  localparam logic [1:0] REG_BACKBUF = 2'd1;
  localparam logic [1:0] REG_RES     = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int BIT_SWAP_PENDING = 0;
  localparam int BIT_DMA_EN       = 2;

endpackage

`default_nettype wire

// File: rtl/video_dma_swap_master.sv
// Avalon-MM master that programs a video DMA: back-buffer swap with status
// polling, or DMA enable update. All outputs are registered.
`default_nettype none

module video_dma_swap_master
  import video_dma_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int POLL_LIMIT   = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_address,
  input  logic        req_enable,
  output logic        req_ready,
  output logic        done,
  output logic        error,
  output logic [1:0]  master_address,
  output logic [3:0]  master_byteenable,
  output logic        master_read,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic [31:0] master_readdata,
  input  logic        master_waitrequest
);

  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int LW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);
  localparam logic [LW-1:0] LAT_MAX  = LW'(READ_LATENCY);

  state_t        state, state_n;
  logic [31:0]   addr_q, addr_n;
  logic          en_q, en_n;
  logic          op_q, op_n;
  logic [31:0]   status_q, status_n;
  logic [PW-1:0] poll_q, poll_n;
  logic [LW-1:0] lat_q, lat_n;

  logic          done_n, error_n, ready_n, rd_n, wr_n;
  logic [1:0]    ma_n;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;

  // Only the pending bit of the status word and none of the latched op are
  // consumed after capture; fold them into a sink so they stay visible.
  logic unused_bits;
  assign unused_bits = ^{status_q[31:1], op_q};

  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    en_n     = en_q;
    op_n     = op_q;
    status_n = status_q;
    poll_n   = poll_q;
    lat_n    = lat_q;
    done_n   = 1'b0;
    error_n  = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_n  = req_address;
          en_n    = req_enable;
          op_n    = req_op;
          state_n = req_op ? S_WR_EN : S_WR_BACK;
        end
      end
      S_WR_BACK: begin
        if (!master_waitrequest) state_n = S_WR_SWAP;
      end
      S_WR_SWAP: begin
        if (!master_waitrequest) begin
          poll_n  = '0;
          state_n = S_RD_STATUS;
        end
      end
      S_WR_EN: begin
        if (!master_waitrequest) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_RD_STATUS: begin
        if (!master_waitrequest) begin
          poll_n  = poll_q + PW'(1);
          lat_n   = LW'(1);
          state_n = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        // lat_q counts cycles since the read was accepted
        if (lat_q == LAT_MAX) begin
          status_n = master_readdata;
          state_n  = S_CHECK;
        end else begin
          lat_n = lat_q + LW'(1);
        end
      end
      S_CHECK: begin
        if (!status_q[BIT_SWAP_PENDING]) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (poll_q == POLL_MAX) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_RD_STATUS;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Bus outputs are decoded from the upcoming state so they register in
    // the same edge as the transition and stay put while stalled.
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    ma_n    = 2'd0;
    be_n    = 4'h0;
    wd_n    = 32'd0;
    ready_n = (state_n == S_IDLE);
    case (state_n)
      S_WR_BACK: begin
        wr_n = 1'b1;
        ma_n = REG_BACKBUF;
        be_n = 4'hF;
        wd_n = addr_n;
      end
      S_WR_SWAP: begin
        wr_n = 1'b1;
        ma_n = REG_BUF;
        be_n = 4'hF;
      end
      S_WR_EN: begin
        wr_n             = 1'b1;
        ma_n             = REG_STATUS;
        be_n             = 4'h1;
        wd_n[BIT_DMA_EN] = en_n;
      end
      S_RD_STATUS: begin
        rd_n = 1'b1;
        ma_n = REG_STATUS;
        be_n = 4'hF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      addr_q            <= 32'd0;
      en_q              <= 1'b0;
      op_q              <= 1'b0;
      status_q          <= 32'd0;
      poll_q            <= '0;
      lat_q             <= '0;
      req_ready         <= 1'b1;
      done              <= 1'b0;
      error             <= 1'b0;
      master_read       <= 1'b0;
      master_write      <= 1'b0;
      master_address    <= 2'd0;
      master_byteenable <= 4'h0;
      master_writedata  <= 32'd0;
    end else begin
      state             <= state_n;
      addr_q            <= addr_n;
      en_q              <= en_n;
      op_q              <= op_n;
      status_q          <= status_n;
      poll_q            <= poll_n;
      lat_q             <= lat_n;
      req_ready         <= ready_n;
      done              <= done_n;
      error             <= error_n;
      master_read       <= rd_n;
      master_write      <= wr_n;
      master_address    <= ma_n;
      master_byteenable <= be_n;
      master_writedata  <= wd_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_video_dma_swap_master.sv
// Randomized bench for video_dma_swap_master against a transaction-level model
// of the expected Avalon traffic and a simple DMA control slave.
`default_nettype none
`timescale 1ns/1ps

module tb_video_dma_swap_master;

  localparam int POLL_LIMIT   = 8;
  localparam int READ_LATENCY = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [31:0] req_address = 32'd0;
  logic        req_enable = 1'b0;
  logic        req_ready, done, error;
  logic [1:0]  master_address;
  logic [3:0]  master_byteenable;
  logic        master_read, master_write;
  logic [31:0] master_writedata;
  logic [31:0] master_readdata = 32'd0;
  logic        master_waitrequest = 1'b0;

  video_dma_swap_master #(
    .READ_LATENCY(READ_LATENCY),
    .POLL_LIMIT  (POLL_LIMIT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_op            (req_op),
    .req_address       (req_address),
    .req_enable        (req_enable),
    .req_ready         (req_ready),
    .done              (done),
    .error             (error),
    .master_address    (master_address),
    .master_byteenable (master_byteenable),
    .master_read       (master_read),
    .master_write      (master_write),
    .master_writedata  (master_writedata),
    .master_readdata   (master_readdata),
    .master_waitrequest(master_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] xf(input logic wr, input logic [1:0] a,
                                     input logic [3:0] be, input logic [31:0] d);
    return {wr, a, be, d};
  endfunction

  // Slave / monitor state
  int          wait_mode = 0;     // 0 none, 1 random, 2 stall backbuf write, 3 stall reads
  int          wb_stall_left = 0;
  int          cfg_npend = 0;     // pending polls armed by each swap write
  int          polls_left = 0;
  int          stall_cycles = 0;
  bit          dma_en = 1'b0;
  bit          rd_pend = 1'b0;
  bit          prev_valid = 1'b0;
  logic        w;
  logic [39:0] prev_bus;
  logic [38:0] got_q[$];
  logic [38:0] exp_q[$];

  initial forever begin
    @(negedge clk);
    if (reset) begin
      master_waitrequest = 1'b0;
      rd_pend = 1'b0;
      prev_valid = 1'b0;
    end else begin
      w = 1'b0;
      case (wait_mode)
        1: w = ($urandom_range(0, 3) == 0);
        2: if (master_write && master_address == 2'd1 && wb_stall_left > 0) begin
             w = 1'b1;
             wb_stall_left--;
           end
        3: w = master_read;
        default: w = 1'b0;
      endcase
      master_waitrequest = w;
      if (rd_pend) begin
        master_readdata = (32'(dma_en) << 2) | 32'(polls_left > 0);
        if (polls_left > 0) polls_left--;
      end else begin
        master_readdata = $urandom() | 32'd1;
      end
      rd_pend = 1'b0;
      if (prev_valid)
        chk("hold", {master_read, master_write, master_address, master_byteenable, master_writedata}, prev_bus);
      chk("rd_wr_excl", master_read & master_write, 0);
      if (master_write && !w) begin
        got_q.push_back(xf(1'b1, master_address, master_byteenable, master_writedata));
        if (master_address == 2'd3 && master_byteenable[0]) dma_en = master_writedata[2];
        if (master_address == 2'd0) polls_left = cfg_npend;
      end
      if (master_read && !w) begin
        got_q.push_back(xf(1'b0, master_address, master_byteenable, 32'd0));
        rd_pend = 1'b1;
      end
      if ((master_read || master_write) && w) stall_cycles++;
      prev_valid = (master_read || master_write) && w;
      prev_bus = {master_read, master_write, master_address, master_byteenable, master_writedata};
    end
  end

  task automatic do_cmd(input bit op, input logic [31:0] addr, input bit en,
                        input int npend, input int mode);
    int p, base, lim, st0;
    int unsigned acc_cyc;
    bit exp_err, seen;
    wait_mode = mode;
    cfg_npend = npend;
    got_q.delete();
    exp_q.delete();
    if (op) begin
      exp_q.push_back(xf(1'b1, 2'd3, 4'h1, {29'd0, en, 2'd0}));
      base = 1;
      exp_err = 1'b0;
    end else begin
      p = (npend + 1 <= POLL_LIMIT) ? npend + 1 : POLL_LIMIT;
      exp_err = (npend >= POLL_LIMIT);
      exp_q.push_back(xf(1'b1, 2'd1, 4'hF, addr));
      exp_q.push_back(xf(1'b1, 2'd0, 4'hF, 32'd0));
      repeat (p) exp_q.push_back(xf(1'b0, 2'd3, 4'hF, 32'd0));
      base = 2 + 3 * p;
    end
    lim = 0;
    while (!req_ready && lim < 50) begin @(negedge clk); lim++; end
    chk("ready_before_req", req_ready, 1);
    st0 = stall_cycles;
    req_valid = 1'b1; req_op = op; req_address = addr; req_enable = en;
    @(negedge clk);
    acc_cyc = cyc;
    seen = 1'b0;
    lim = 0;
    while (!seen && lim < 400) begin
      if (done || error) seen = 1'b1;
      else begin
        // Requests while busy must be ignored
        req_valid = $urandom_range(0, 1); req_op = $urandom_range(0, 1);
        req_address = $urandom(); req_enable = $urandom_range(0, 1);
        @(negedge clk);
        lim++;
      end
    end
    req_valid = 1'b0;
    chk("completion_seen", seen, 1);
    if (seen) begin
      chk("done", done, exp_err ? 0 : 1);
      chk("error", error, exp_err ? 1 : 0);
      chk("latency", cyc - acc_cyc, base + (stall_cycles - st0));
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("error_one_cycle", error, 0);
      chk("ready_after", req_ready, 1);
      chk("n_xfer", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        chk("xfer", got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int lim;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_strobes", {master_read, master_write}, 0);
    chk("rst_bus", {master_address, master_byteenable, master_writedata}, 0);

    do_cmd(1'b0, 32'h0800_0000, 1'b0, 0, 0);       // basic swap, 5-cycle latency
    wb_stall_left = 3;
    do_cmd(1'b0, $urandom(), 1'b0, 0, 2);           // 3-cycle stall on backbuf write
    chk("wb_stalls_used", wb_stall_left, 0);
    do_cmd(1'b0, $urandom(), 1'b0, 4, 0);           // 5 polls
    do_cmd(1'b0, $urandom(), 1'b0, 100, 0);         // pending never clears -> error
    do_cmd(1'b1, 32'd0, 1'b1, 0, 0);
    do_cmd(1'b1, 32'd0, 1'b0, 0, 0);
    chk("dma_en_model", dma_en, 0);

    // Reset while a status read is stalled
    wait_mode = 3; cfg_npend = 2;
    req_valid = 1'b1; req_op = 1'b0; req_address = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    lim = 0;
    while (!master_read && lim < 50) begin @(negedge clk); lim++; end
    chk("reach_rd", master_read, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobes", {master_read, master_write}, 0);
    chk("mid_rst_flags", {done, error}, 0);
    chk("mid_rst_bus", {master_address, master_byteenable, master_writedata}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    do_cmd(1'b0, 32'hCAFE_0000, 1'b0, 1, 0);

    for (int k = 0; k < 20; k++)
      do_cmd($urandom_range(0, 1), $urandom(), $urandom_range(0, 1), $urandom_range(0, 9), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
